// File: rtl/camera_stream_if.sv
// camera_stream_if: pixel stream bundle between the camera source and its sink.
//   data_valid : source has a pixel on data_out
//   data_ready : sink accepts the pixel this cycle
//   data_out   : pixel value, DW bits
//   sof/eol/eof: first-of-frame / last-of-line / last-of-frame markers,
//                qualified by data_valid
interface camera_stream_if #(
  parameter int unsigned DW = 8
);
  logic          data_valid;
  logic          data_ready;
  logic [DW-1:0] data_out;
  logic          sof;
  logic          eol;
  logic          eof;

  modport master (
    output data_valid, data_out, sof, eol, eof,
    input  data_ready
  );

  modport slave (
    input  data_valid, data_out, sof, eol, eof,
    output data_ready
  );
endinterface

// File: rtl/camera_stream.sv
// camera_stream: raster frame source for the image-filter pipeline.
// Emits IMG_W x IMG_H pixel frames from a selectable pattern generator
// (ramp, checkerboard, fixed table, constant fill) with valid/ready
// backpressure, frame/line markers and a completed-frame counter.
// Optional macro CAMERA_BLANKING_EN inserts HBLANK idle cycles between lines
// and VBLANK idle cycles after each frame.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   camera_en   : start a frame at a frame boundary when high
//   mode        : pattern select (0 ramp, 1 checker, 2 table, 3 fill), latched at frame start
//   fill_value  : constant pixel for mode 3, latched at frame start
//   vid         : pixel stream (master side)
//   busy        : high from frame start until the frame (and VBLANK) completes
//   frame_cnt   : completed frame count, wraps
module camera_stream #(
  parameter int unsigned DW        = 8,
  parameter int unsigned IMG_W     = 4,
  parameter int unsigned IMG_H     = 3,
  parameter int unsigned CHK_SHIFT = 1,
  parameter int unsigned HBLANK    = 2,
  parameter int unsigned VBLANK    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  camera_en,
  input  logic [1:0]            mode,
  input  logic [DW-1:0]         fill_value,
  camera_stream_if.master       vid,
  output logic                  busy,
  output logic [15:0]           frame_cnt
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_HBLANK = 2'd2,
    S_VBLANK = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [RW-1:0] row, row_n;
  logic [CW-1:0] col, col_n;
  logic          start;       // a frame begins at this edge
  logic          frame_done;  // eof pixel transfers at this edge
  logic          xfer;

  logic [1:0]    mode_q, mode_eff;
  logic [DW-1:0] fill_q, fill_eff;

  logic          valid_q, valid_n;
  logic [DW-1:0] data_q,  data_n;
  logic          sof_q,   sof_n;
  logic          eol_q,   eol_n;
  logic          eof_q,   eof_n;
  logic          busy_n;

`ifdef CAMERA_BLANKING_EN
  localparam int unsigned BLANK_MAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int unsigned BW        = (BLANK_MAX > 1) ? $clog2(BLANK_MAX) : 1;
  localparam logic [BW-1:0] HB_LOAD = BW'((HBLANK > 0) ? HBLANK - 1 : 0);
  localparam logic [BW-1:0] VB_LOAD = BW'((VBLANK > 0) ? VBLANK - 1 : 0);
  logic [BW-1:0] blank_cnt, blank_n;
`else
  // Blanking counts are accepted but have no effect without CAMERA_BLANKING_EN.
  if ((HBLANK > 32'hFFFF) || (VBLANK > 32'hFFFF)) begin : g_blank_cfg_ignored
  end
`endif

  assign xfer = valid_q && vid.data_ready;

  // Pattern selection is taken live at the start edge, latched afterwards.
  assign mode_eff = start ? mode       : mode_q;
  assign fill_eff = start ? fill_value : fill_q;

  function automatic logic [7:0] table_byte(input logic [3:0] i);
    case (i)
      4'd0:    table_byte = 8'hBC;
      4'd1:    table_byte = 8'h27;
      4'd2:    table_byte = 8'h81;
      4'd3:    table_byte = 8'hFF;
      4'd4:    table_byte = 8'hCE;
      4'd5:    table_byte = 8'h1F;
      4'd6:    table_byte = 8'hE0;
      4'd7:    table_byte = 8'hA9;
      4'd8:    table_byte = 8'h38;
      4'd9:    table_byte = 8'h2B;
      4'd10:   table_byte = 8'hD4;
      4'd11:   table_byte = 8'h11;
      default: table_byte = 8'h00;
    endcase
  endfunction

  // Pixel value for position (r, c) under pattern m.
  function automatic logic [DW-1:0] pixel_at(
    input logic [1:0]    m,
    input logic [DW-1:0] fill,
    input logic [RW-1:0] r,
    input logic [CW-1:0] c
  );
    logic [31:0] idx;
    logic [31:0] chk;
    logic [31:0] tbl;
    idx = 32'(r) * IMG_W + 32'(c);
    chk = (32'(r) >> CHK_SHIFT) ^ (32'(c) >> CHK_SHIFT);
    tbl = {24'd0, table_byte(4'(idx % 32'd12))};
    case (m)
      2'd0:    pixel_at = DW'(idx);
      2'd1:    pixel_at = ((chk & 32'd1) != 32'd0) ? {DW{1'b1}} : {DW{1'b0}};
      2'd2:    pixel_at = DW'(tbl);
      default: pixel_at = fill;
    endcase
  endfunction

  // State register and raster position.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      row   <= '0;
      col   <= '0;
`ifdef CAMERA_BLANKING_EN
      blank_cnt <= '0;
`endif
    end else begin
      state <= state_n;
      row   <= row_n;
      col   <= col_n;
`ifdef CAMERA_BLANKING_EN
      blank_cnt <= blank_n;
`endif
    end
  end

  // Next state, raster advance and frame boundary events.
  always_comb begin
    state_n    = state;
    row_n      = row;
    col_n      = col;
    start      = 1'b0;
    frame_done = 1'b0;
`ifdef CAMERA_BLANKING_EN
    blank_n    = blank_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (camera_en) begin
          state_n = S_ACTIVE;
          row_n   = '0;
          col_n   = '0;
          start   = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (xfer) begin
          if (col == COL_LAST) begin
            col_n = '0;
            if (row == ROW_LAST) begin
              row_n      = '0;
              frame_done = 1'b1;
`ifdef CAMERA_BLANKING_EN
              if (VBLANK > 0) begin
                state_n = S_VBLANK;
                blank_n = VB_LOAD;
              end else if (camera_en) begin
                start = 1'b1;
              end else begin
                state_n = S_IDLE;
              end
`else
              if (camera_en) begin
                start = 1'b1;
              end else begin
                state_n = S_IDLE;
              end
`endif
            end else begin
              row_n = row + RW'(1);
`ifdef CAMERA_BLANKING_EN
              if (HBLANK > 0) begin
                state_n = S_HBLANK;
                blank_n = HB_LOAD;
              end
`endif
            end
          end else begin
            col_n = col + CW'(1);
          end
        end
      end
`ifdef CAMERA_BLANKING_EN
      S_HBLANK: begin
        if (blank_cnt == '0) begin
          state_n = S_ACTIVE;
        end else begin
          blank_n = blank_cnt - BW'(1);
        end
      end
      S_VBLANK: begin
        if (blank_cnt == '0) begin
          if (camera_en) begin
            state_n = S_ACTIVE;
            start   = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          blank_n = blank_cnt - BW'(1);
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  // Output values for the next cycle; a stalled pixel recomputes to itself.
  always_comb begin
    valid_n = (state_n == S_ACTIVE);
    busy_n  = (state_n != S_IDLE);
    data_n  = '0;
    sof_n   = 1'b0;
    eol_n   = 1'b0;
    eof_n   = 1'b0;
    if (valid_n) begin
      data_n = pixel_at(mode_eff, fill_eff, row_n, col_n);
      sof_n  = (row_n == '0) && (col_n == '0);
      eol_n  = (col_n == COL_LAST);
      eof_n  = (col_n == COL_LAST) && (row_n == ROW_LAST);
    end
  end

  // Output registers, pattern latch and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
      mode_q    <= '0;
      fill_q    <= '0;
    end else begin
      valid_q <= valid_n;
      data_q  <= data_n;
      sof_q   <= sof_n;
      eol_q   <= eol_n;
      eof_q   <= eof_n;
      busy    <= busy_n;
      if (frame_done) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (start) begin
        mode_q <= mode;
        fill_q <= fill_value;
      end
    end
  end

  assign vid.data_valid = valid_q;
  assign vid.data_out   = data_q;
  assign vid.sof        = sof_q;
  assign vid.eol        = eol_q;
  assign vid.eof        = eof_q;

endmodule

// File: tb/tb_camera_stream.sv
// tb_camera_stream: directed sequence of frames with random backpressure and
// random mid-frame mode/fill changes, checked against a raster model.
module tb_camera_stream;

  localparam int unsigned DW    = 8;
  localparam int unsigned IMG_W = 4;
  localparam int unsigned IMG_H = 3;
  localparam int          NPIX  = IMG_W * IMG_H;
`ifdef CAMERA_BLANKING_EN
  localparam int HB_EXP = 2;
  localparam int VB_EXP = 4;
`else
  localparam int HB_EXP = 0;
  localparam int VB_EXP = 0;
`endif
  localparam logic [7:0] TBL [12] = '{8'hBC, 8'h27, 8'h81, 8'hFF, 8'hCE, 8'h1F,
                                       8'hE0, 8'hA9, 8'h38, 8'h2B, 8'hD4, 8'h11};

  logic          clk = 1'b0;
  logic          rst;
  logic          camera_en;
  logic [1:0]    mode;
  logic [DW-1:0] fill_value;
  logic          busy;
  logic [15:0]   frame_cnt;

  camera_stream_if #(.DW(DW)) vid ();

  camera_stream #(
    .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .CHK_SHIFT(1), .HBLANK(2), .VBLANK(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .camera_en  (camera_en),
    .mode       (mode),
    .fill_value (fill_value),
    .vid        (vid),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int fc_exp  = 0;

  // Expected pixel p (counted across consecutive frames) for pattern m.
  function automatic logic [7:0] model_pix(input int p, input logic [1:0] m, input logic [7:0] f);
    int k, r, c;
    k = p % NPIX;
    r = k / IMG_W;
    c = k % IMG_W;
    case (m)
      2'd0:    return 8'(k);
      2'd1:    return (((r / 2) + (c / 2)) % 2 == 1) ? 8'hFF : 8'h00;
      2'd2:    return TBL[k];
      default: return f;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start from IDLE, consume npix pixels, drop camera_en once en_off pixels
  // have been accepted; optionally wait for the return to IDLE.
  task automatic stream(input int npix, input logic [1:0] m, input logic [7:0] f,
                        input int rdy_pct, input int en_off, input bit to_idle);
    int p, gap, budget, gexp;
    logic pv, pr;
    logic [7:0] pd;
    logic [2:0] pflags;
    mode            = m;
    fill_value      = f;
    camera_en       = 1'b1;
    vid.data_ready  = 1'b0;
    tick();
    check("start_latency", 32'(vid.data_valid), 32'd1);
    p = 0; gap = 0; pv = 1'b0; pr = 1'b0; pd = '0; pflags = '0;
    budget = npix * 40 + 50;
    while (p < npix && budget > 0) begin
      budget--;
      check("busy_active", 32'(busy), 32'd1);
      if (vid.data_valid) begin
        if (pv && !pr) begin
          check("hold_data", 32'(vid.data_out), 32'(pd));
          check("hold_flags", 32'({vid.sof, vid.eol, vid.eof}), 32'(pflags));
        end else begin
          if (p > 0) begin
            gexp = (p % NPIX == 0) ? VB_EXP : ((p % IMG_W == 0) ? HB_EXP : 0);
            check("blank_gap", 32'(gap), 32'(gexp));
          end
          check("pixel", 32'(vid.data_out), 32'(model_pix(p, m, f)));
          check("sof", 32'(vid.sof), 32'(p % NPIX == 0));
          check("eol", 32'(vid.eol), 32'(p % IMG_W == IMG_W - 1));
          check("eof", 32'(vid.eof), 32'(p % NPIX == NPIX - 1));
          check("frame_cnt_mid", 32'(frame_cnt), 32'((fc_exp + p / NPIX) & 16'hFFFF));
        end
      end else begin
        check("invalid_zero", {vid.data_out, vid.sof, vid.eol, vid.eof}, 32'd0);
        gap++;
      end
      pv     = vid.data_valid;
      pd     = vid.data_out;
      pflags = {vid.sof, vid.eol, vid.eof};
      pr     = ($urandom_range(99) < rdy_pct);
      vid.data_ready = pr;
      if (vid.data_valid && pr) begin
        p++;
        gap = 0;
      end
      if (p >= en_off) camera_en = 1'b0;
      // Pattern inputs are only meaningful at a frame start.
      if (p % NPIX == 0) begin
        mode       = m;
        fill_value = f;
      end else begin
        mode       = 2'($urandom);
        fill_value = 8'($urandom);
      end
      tick();
    end
    check("stream_count", 32'(p), 32'(npix));
    fc_exp += npix / NPIX;
    if (to_idle) begin
      budget = VB_EXP + 10;
      while (busy && budget > 0) begin
        check("vblank_invalid", 32'(vid.data_valid), 32'd0);
        budget--;
        tick();
      end
      check("back_to_idle", 32'(busy), 32'd0);
      check("idle_valid", 32'(vid.data_valid), 32'd0);
      check("frame_cnt", 32'(frame_cnt), 32'(fc_exp));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    camera_en      = 1'b0;
    mode           = 2'd0;
    fill_value     = '0;
    vid.data_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(vid.data_valid), 32'd0);
    check("rst_outputs", {vid.data_out, vid.sof, vid.eol, vid.eof}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("idle_no_start", 32'(vid.data_valid), 32'd0);

    // Ramp, full throughput, one-cycle enable pulse.
    stream(NPIX, 2'd0, 8'h00, 100, 0, 1'b1);
    // Table pattern.
    stream(NPIX, 2'd2, 8'h00, 100, 0, 1'b1);
    // Ramp under heavy backpressure.
    stream(NPIX, 2'd0, 8'h00, 50, 0, 1'b1);
    // Checkerboard, two frames back-to-back with enable held.
    stream(2 * NPIX, 2'd1, 8'h00, 100, 2 * NPIX - 1, 1'b1);
    // Fill, enable dropped after six pixels.
    stream(NPIX, 2'd3, 8'($urandom), 70, 6, 1'b1);
    // Random patterns, three frames each.
    for (int i = 0; i < 4; i++) begin
      stream(3 * NPIX, 2'($urandom), 8'($urandom), 30 + 20 * i, 3 * NPIX - 1, 1'b1);
    end

    // Reset right after pixel 07 has transferred.
    stream(8, 2'd0, 8'h00, 100, 1000, 1'b0);
    rst       = 1'b1;
    camera_en = 1'b0;
    tick();
    check("midrst_valid", 32'(vid.data_valid), 32'd0);
    check("midrst_outputs", {vid.data_out, vid.sof, vid.eol, vid.eof}, 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst    = 1'b0;
    fc_exp = 0;
    tick();
    check("post_rst_idle", 32'(vid.data_valid), 32'd0);
    stream(NPIX, 2'd0, 8'h00, 100, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/camera_stream.md
Name: camera_stream

Overview:
Parametrised successor to the fixed 12-byte camera stub. Emits complete raster frames of IMG_W x IMG_H pixels, DW bits each, using a selectable pattern generator. Adds valid/ready backpressure, frame and line markers, a frame counter and synchronous reset. Sits at the head of the image-filter pipeline as the stimulus source feeding the line buffers and filter kernels.

Parameters:
DW, 8, pixel data width in bits (1..32)
IMG_W, 4, pixels per line (>=2)
IMG_H, 3, lines per frame (>=2)
CHK_SHIFT, 1, checkerboard tile size is 2**CHK_SHIFT pixels
HBLANK, 2, idle cycles between lines (used only with CAMERA_BLANKING_EN; 0 allowed)
VBLANK, 4, idle cycles after a frame (used only with CAMERA_BLANKING_EN; 0 allowed)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
camera_en  in  1  camera enable; frame starts only when high at a frame boundary
mode  in  2  pattern select, sampled at frame start: 0 ramp, 1 checker, 2 table, 3 fill
fill_value  in  DW  constant pixel for mode 3, sampled at frame start
data_ready  in  1  downstream accepts pixel this cycle
data_valid  out  1  data_out holds a valid pixel
data_out  out  DW  pixel value
sof  out  1  first pixel of frame (qualified by data_valid)
eol  out  1  last pixel of line (qualified by data_valid)
eof  out  1  last pixel of frame (qualified by data_valid)
busy  out  1  high from frame start until frame (and VBLANK if enabled) completes
frame_cnt  out  16  count of completed frames, wraps 0xFFFF->0

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; data_valid, data_out, sof, eol, eof, busy, frame_cnt, row, col all 0. Reset mid-frame aborts immediately; no eof, frame_cnt not incremented.
- States: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE: outputs 0. camera_en=1 at edge N -> ACTIVE, data_valid=1 with pixel (0,0) and sof=1 from edge N (visible cycle N+1); mode/fill_value latched at that edge.
- Handshake: pixel transfers when data_valid && data_ready. While data_valid && !data_ready, data_out/sof/eol/eof hold stable. data_valid never drops without a transfer while ACTIVE.
- On transfer: col increments; at col==IMG_W-1, col->0, row increments; at row==IMG_H-1 and col==IMG_W-1 (eof), frame_cnt+1.
- Next pixel presented the cycle after transfer (one pixel per cycle at ready=1, no bubbles without blanking).
- Pixel value, idx=row*IMG_W+col:
  - mode 0: idx mod 2**DW.
  - mode 1: ((row>>CHK_SHIFT) ^ (col>>CHK_SHIFT)) bit0 ? all-ones : 0.
  - mode 2: TABLE[idx mod 12], TABLE = BC,27,81,FF,CE,1F,E0,A9,38,2B,D4,11; zero-extended if DW>8, low DW bits if DW<8.
  - mode 3: latched fill_value.
- camera_en deasserted mid-frame: current frame completes normally; after eof -> IDLE (via VBLANK if enabled). camera_en high at eof transfer -> next frame back-to-back (or after VBLANK). mode changes mid-frame ignored.
- busy=1 in ACTIVE/HBLANK/VBLANK, 0 in IDLE.
- No tri-state outputs; data_out=0 whenever data_valid=0.

Optional Feature:
CAMERA_BLANKING_EN
- Defined: after non-final eol transfer -> HBLANK for HBLANK cycles (data_valid=0), then ACTIVE; after eof transfer -> VBLANK for VBLANK cycles, then ACTIVE if camera_en else IDLE. Count 0 skips the state.
- Undefined: HBLANK/VBLANK states and counters not built; lines back-to-back; eof -> ACTIVE (camera_en=1) or IDLE.

Test Plan:
- Defaults, blanking off, mode 0, ready=1, camera_en pulse 1 cycle -> 12 valid cycles 00..0B; sof on 00; eol on 03,07,0B; eof on 0B; frame_cnt=1; then IDLE, busy=0.
- mode 2, ready=1 -> data_out BC,27,81,FF,CE,1F,E0,A9,38,2B,D4,11; DW=12 build -> 0BC,027,... .
- mode 0, ready toggled 1,0,0,1,... -> each pixel held stable across stalls; sequence still 00..0B, no duplicates or drops.
- CAMERA_BLANKING_EN, mode 1, camera_en held -> checker 00,00,FF,FF / 00,00,FF,FF / FF,FF,00,00; 2 invalid cycles after each of lines 0,1; 4 after eof; second frame sof follows; frame_cnt increments per frame.
- camera_en dropped after pixel 05 -> pixels 06..0B still delivered with eof, then IDLE; frame_cnt=1.
- rst asserted after pixel 07 -> next cycle all outputs 0, frame_cnt=0; camera_en restart begins at pixel 00 with sof.
